rc4_keystream: RTL and testbench

RC4_KEYSTREAM -- requirements
Module: rc4_keystream

---
 rtl/rc4_keystream_if.sv | 29 ++
 rtl/rc4_keystream.sv | 199 +++++++++++++++++++
 tb/tb_rc4_keystream.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_keystream_if.sv
// rc4_keystream_if: key-load and keystream handshake bundle for rc4_keystream.
// The master side (key source / keystream consumer) drives start, key_len,
// key_in, key_valid and ks_ready; the slave side (the generator) returns
// key_ready, ks_data, ks_valid and busy.
interface rc4_keystream_if #(
   parameter int MAX_KEY_LEN = 16
) ();
   localparam int KLW = $clog2(MAX_KEY_LEN + 1);

   logic           start;
   logic [KLW-1:0] key_len;
   logic [7:0]     key_in;
   logic           key_valid;
   logic           key_ready;
   logic [7:0]     ks_data;
   logic           ks_valid;
   logic           ks_ready;
   logic           busy;

   modport master (
      output start, key_len, key_in, key_valid, ks_ready,
      input  key_ready, ks_data, ks_valid, busy
   );

   modport slave (
      input  start, key_len, key_in, key_valid, ks_ready,
      output key_ready, ks_data, ks_valid, busy
   );
endinterface

// File: rtl/rc4_keystream.sv
// rc4_keystream: RC4 key scheduling plus keystream generator, one byte per
// two clocks. The key is loaded byte by byte, S is initialised and permuted
// (KSA) one step per cycle pair, then PRGA bytes go out through a
// valid/ready output register.
// Optional feature: define RC4_DISCARD_EN to drop the first DISCARD bytes
// generated after every key schedule.
module rc4_keystream #(
   parameter int MAX_KEY_LEN = 16,
   parameter int DISCARD     = 1000
) (
   input logic            clk,
   input logic            rst,
   rc4_keystream_if.slave bus
);
   localparam int KLW = $clog2(MAX_KEY_LEN + 1);
   // key index width; key storage is rounded up to a power of two
   localparam int KIW = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;

   typedef enum logic [2:0] {
      IDLE, KEYLOAD, INIT, KSA_J, KSA_SWAP, PRGA_J, PRGA_OUT
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     i_q, i_d, j_q, j_d;
   logic [KIW-1:0] kidx_q, kidx_d;     // key load index, then i mod len in KSA
   logic [KIW-1:0] len_m1_q, len_m1_d; // latched key length minus one
   logic [7:0]     ks_data_q, ks_data_d;
   logic           ks_valid_q, ks_valid_d;

   logic [7:0]     s_q   [256];
   logic [7:0]     key_q [2**KIW];

   logic           s_init_we, s_swap_we, key_we;
   logic [7:0]     si, sj, t, st, i_inc, s_inc, ks_byte;
   logic [KLW-1:0] eff_len;
   logic [KIW-1:0] start_len_m1;
   logic           stall, drop;

`ifdef RC4_DISCARD_EN
   localparam int DW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
   logic [DW-1:0] disc_q, disc_d;
   assign drop = (disc_q < DW'(DISCARD));
`else
   assign drop = 1'b0;
`endif

   // S reads: KSA/PRGA operands, post-swap output byte from pre-swap values
   assign si      = s_q[i_q];
   assign sj      = s_q[j_q];
   assign t       = si + sj;
   assign st      = s_q[t];
   assign ks_byte = (t == i_q) ? sj : ((t == j_q) ? si : st);
   assign i_inc   = i_q + 8'd1;
   assign s_inc   = s_q[i_inc];
   assign stall   = ks_valid_q & ~bus.ks_ready;

   // zero or oversize key_len means a full-length key
   assign eff_len = ((bus.key_len == '0) || (bus.key_len > KLW'(MAX_KEY_LEN)))
                    ? KLW'(MAX_KEY_LEN) : bus.key_len;
   assign start_len_m1 = KIW'(eff_len - KLW'(1));

   // next-state, index arithmetic and output-register update
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      kidx_d     = kidx_q;
      len_m1_d   = len_m1_q;
      ks_data_d  = ks_data_q;
      ks_valid_d = ks_valid_q & ~bus.ks_ready;
      s_init_we  = 1'b0;
      s_swap_we  = 1'b0;
      key_we     = 1'b0;
`ifdef RC4_DISCARD_EN
      disc_d     = disc_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_m1_d = start_len_m1;
               kidx_d   = '0;
               state_d  = KEYLOAD;
            end
         end
         KEYLOAD: begin
            if (bus.key_valid) begin
               key_we = 1'b1;
               if (kidx_q == len_m1_q) begin
                  kidx_d  = '0;
                  i_d     = '0;
                  state_d = INIT;
               end else begin
                  kidx_d = kidx_q + 1'b1;
               end
            end
         end
         INIT: begin
            s_init_we = 1'b1;
            i_d       = i_inc;
            if (i_q == 8'd255) begin
               j_d     = '0;
               state_d = KSA_J;
            end
         end
         KSA_J: begin
            j_d     = j_q + si + key_q[kidx_q];
            state_d = KSA_SWAP;
         end
         KSA_SWAP: begin
            s_swap_we = 1'b1;
            kidx_d    = (kidx_q == len_m1_q) ? '0 : kidx_q + 1'b1;
            i_d       = i_inc;
            if (i_q == 8'd255) begin
               j_d     = '0;
               state_d = PRGA_J;
`ifdef RC4_DISCARD_EN
               disc_d  = '0;
`endif
            end else begin
               state_d = KSA_J;
            end
         end
         PRGA_J: begin
            // hold everything while the consumer has not taken the last byte
            if (!stall) begin
               i_d     = i_inc;
               j_d     = j_q + s_inc;
               state_d = PRGA_OUT;
            end
         end
         PRGA_OUT: begin
            s_swap_we = 1'b1;
            state_d   = PRGA_J;
            if (!drop) begin
               ks_data_d  = ks_byte;
               ks_valid_d = 1'b1;
            end
`ifdef RC4_DISCARD_EN
            else begin
               disc_d = disc_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      // rekey is only honoured once keystream generation is running
      if (bus.start && ((state_q == PRGA_J) || (state_q == PRGA_OUT))) begin
         ks_valid_d = 1'b0;
         len_m1_d   = start_len_m1;
         kidx_d     = '0;
         s_swap_we  = 1'b0;
         state_d    = KEYLOAD;
      end
   end

   // control and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         i_q        <= '0;
         j_q        <= '0;
         kidx_q     <= '0;
         len_m1_q   <= '0;
         ks_data_q  <= '0;
         ks_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         kidx_q     <= kidx_d;
         len_m1_q   <= len_m1_d;
         ks_data_q  <= ks_data_d;
         ks_valid_q <= ks_valid_d;
      end
   end

`ifdef RC4_DISCARD_EN
   // discard counter, restarted at the end of every key schedule
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) disc_q <= '0;
      else      disc_q <= disc_d;
   end
`endif

   // S box and key storage; contents are rebuilt on every start, so no reset
   always_ff @(posedge clk) begin
      if (s_init_we) s_q[i_q] <= i_q;
      if (s_swap_we) begin
         s_q[i_q] <= sj;
         s_q[j_q] <= si;
      end
      if (key_we) key_q[kidx_q] <= bus.key_in;
   end

   assign bus.ks_data   = ks_data_q;
   assign bus.ks_valid  = ks_valid_q;
   assign bus.key_ready = (state_q == KEYLOAD);
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_rc4_keystream.sv
// tb_rc4_keystream: directed bench for rc4_keystream with a keystream
// scoreboard. Known RC4 vectors ("Key", "Wiki", "Secret") are pushed when a
// key is loaded and popped as bytes are handed off. A second instance with
// MAX_KEY_LEN=4 covers the zero key_len case.
module tb_rc4_keystream;
   localparam int MKL  = 16;
   localparam int KLW  = $clog2(MKL + 1);
   localparam int KLW4 = $clog2(4 + 1);
`ifdef RC4_DISCARD_EN
   localparam int DSK = 3;
`else
   localparam int DSK = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rc4_keystream_if #(.MAX_KEY_LEN(MKL)) u_if ();
   rc4_keystream_if #(.MAX_KEY_LEN(4))   u_if4 ();

   rc4_keystream #(.MAX_KEY_LEN(MKL), .DISCARD(3)) u_dut (
      .clk(clk), .rst(rst), .bus(u_if)
   );
   rc4_keystream #(.MAX_KEY_LEN(4), .DISCARD(3)) u_dut4 (
      .clk(clk), .rst(rst), .bus(u_if4)
   );

   logic [7:0] key_k [16] = '{8'h4B, 8'h65, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] key_w [16] = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] key_s [16] = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] exp_k [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
   logic [7:0] exp_w [6]  = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
   logic [7:0] exp_s [8]  = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         prev_hs = -1;
   int         first_vld_cyc = -1;
   int         last_acc = 0;
   bit         gap_chk = 1'b0;
   bit         stall_prev = 1'b0;
   logic [7:0] stall_data = '0;
   logic [7:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // per-cycle observation of the main instance, done at the falling edge
   task automatic monitor();
      if (rst) begin
         if (stall_prev) begin
            check("stall_valid_held", u_if.ks_valid, 1);
            check("stall_data_stable", u_if.ks_data, stall_data);
         end
         if (u_if.ks_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (u_if.ks_valid && u_if.ks_ready && sb.size() != 0) begin
            check("ks_byte", u_if.ks_data, sb.pop_front());
            if (gap_chk && prev_hs >= 0) check("ks_spacing", cyc - prev_hs, 2);
            prev_hs = cyc;
         end
         stall_prev = u_if.ks_valid && !u_if.ks_ready && !u_if.start;
         stall_data = u_if.ks_data;
      end else begin
         stall_prev = 1'b0;
      end
   endtask

   // one clock: monitor at negedge, then return just after the rising edge
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send_key(input logic [7:0] kb [16], input int n, input int klen, input bit gaps);
      u_if.start   = 1'b1;
      u_if.key_len = KLW'(klen);
      step();
      u_if.start = 1'b0;
      first_vld_cyc = -1;
      check("start_clears_valid", u_if.ks_valid, 0);
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            u_if.key_valid = 1'b0;
            u_if.key_in    = 8'hA5;
            step();
         end
         u_if.key_valid = 1'b1;
         u_if.key_in    = kb[k];
         check("key_ready", u_if.key_ready, 1);
         step();
      end
      u_if.key_valid = 1'b0;
      last_acc = cyc;
   endtask

   task automatic drain(input bit rnd, input int budget);
      int k;
      k = 0;
      prev_hs = -1;
      while (sb.size() != 0 && k < budget) begin
         u_if.ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         k++;
      end
      check("drain_complete", sb.size(), 0);
      u_if.ks_ready = 1'b0;
      sb.delete();
   endtask

   initial begin
      int w;
      rst = 1'b0;
      u_if.start = 1'b0;  u_if.key_len = '0;  u_if.key_in = '0;
      u_if.key_valid = 1'b0;  u_if.ks_ready = 1'b0;
      u_if4.start = 1'b0; u_if4.key_len = '0; u_if4.key_in = '0;
      u_if4.key_valid = 1'b0; u_if4.ks_ready = 1'b1;
      #2;
      check("rst_busy", u_if.busy, 0);
      check("rst_ks_valid", u_if.ks_valid, 0);
      check("rst_ks_data", u_if.ks_data, 0);
      check("rst_key_ready", u_if.key_ready, 0);
      check("rst_busy4", u_if4.busy, 0);
      step(); step();
      rst = 1'b1;
      step();

      // "Key", key_valid toggling, ready high: values, spacing and latency
      send_key(key_k, 3, 3, 1'b1);
      for (int k = DSK; k < 10; k++) sb.push_back(exp_k[k]);
      gap_chk = 1'b1;
      drain(1'b0, 1500);
      check("latency", first_vld_cyc - last_acc, 770 + 2 * DSK);

      // rekey from a stalled output, then random backpressure
      send_key(key_k, 3, 3, 1'b0);
      for (int k = DSK; k < 10; k++) sb.push_back(exp_k[k]);
      gap_chk = 1'b0;
      drain(1'b1, 4000);

      // "Wiki" with a start pulse during INIT that must be ignored
      send_key(key_w, 4, 4, 1'b0);
      repeat (20) step();
      u_if.start   = 1'b1;
      u_if.key_len = KLW'(1);
      step();
      u_if.start = 1'b0;
      check("start_in_init_busy", u_if.busy, 1);
      check("start_in_init_no_keyload", u_if.key_ready, 0);
      for (int k = DSK; k < 6; k++) sb.push_back(exp_w[k]);
      gap_chk = 1'b1;
      drain(1'b0, 1500);

      // rekey to "Secret"
      send_key(key_s, 6, 6, 1'b0);
      for (int k = DSK; k < 8; k++) sb.push_back(exp_s[k]);
      drain(1'b0, 1500);

      // asynchronous reset while a byte is stalled in the output register
      repeat (3) step();
      check("stalled_before_rst", u_if.ks_valid, 1);
      #2 rst = 1'b0;
      stall_prev = 1'b0;
      #1;
      check("async_rst_ks_valid", u_if.ks_valid, 0);
      check("async_rst_ks_data", u_if.ks_data, 0);
      check("async_rst_busy", u_if.busy, 0);
      check("async_rst_key_ready", u_if.key_ready, 0);
      step();
      rst = 1'b1;
      step();

      // reset during INIT
      send_key(key_k, 3, 3, 1'b0);
      repeat (50) step();
      check("init_busy", u_if.busy, 1);
      #2 rst = 1'b0;
      #1;
      check("init_rst_busy", u_if.busy, 0);
      check("init_rst_ks_valid", u_if.ks_valid, 0);
      step();
      rst = 1'b1;
      step();

      // full rebuild after the aborted schedule
      send_key(key_k, 3, 3, 1'b0);
      for (int k = DSK; k < 10; k++) sb.push_back(exp_k[k]);
      gap_chk = 1'b1;
      drain(1'b0, 1500);

      // MAX_KEY_LEN=4 instance: key_len=0 means four key bytes
      u_if4.start   = 1'b1;
      u_if4.key_len = KLW4'(0);
      step();
      u_if4.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         u_if4.key_valid = 1'b1;
         u_if4.key_in    = key_w[k];
         check("len0_key_ready", u_if4.key_ready, 1);
         step();
      end
      u_if4.key_in = 8'hFF;
      check("len0_fifth_refused", u_if4.key_ready, 0);
      step();
      u_if4.key_valid = 1'b0;
      for (int k = DSK; k < 6; k++) begin
         w = 0;
         while (!u_if4.ks_valid && w < 2000) begin
            step();
            w++;
         end
         check("len0_valid", u_if4.ks_valid, 1);
         check("len0_byte", u_if4.ks_data, exp_w[k]);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
